// File: rtl/scroll_controller.sv
`default_nettype none
// ============================================================================
// Module   : scroll_controller
// Function : Holds a message of up to 16 character codes and scrolls a
//            circular 8-slot window over it at a fixed rate.
// Revision : 1.0 - initial release
// ============================================================================
module scroll_controller #(
  parameter int SHIFT_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       dir,
  output logic [4:0] char0,
  output logic [4:0] char1,
  output logic [4:0] char2,
  output logic [4:0] char3,
  output logic [4:0] char4,
  output logic [4:0] char5,
  output logic [4:0] char6,
  output logic [4:0] char7,
  output logic       busy,
  output logic       wrap
);

  localparam int               DIV_W      = (SHIFT_DIV > 2) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SHIFT_DIV - 1);
  localparam logic [4:0]       c_blank    = 5'd16;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [4:0]       r_buf [16];
  logic [4:0]       r_len;
  logic [3:0]       r_ofs;
  logic [DIV_W-1:0] r_div;
  logic             r_wrap;
  logic [4:0]       r_char [8];

  logic             w_len_ok;
  logic             w_load;
  logic             w_tick;
  logic             w_shift;
  logic             w_wraps;
  logic [3:0]       w_last;
  logic [3:0]       w_ofs_nxt;
  logic [3:0]       w_idx [8];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_len_ok = (msg_len != 5'd0) && (msg_len <= 5'd16);

  // --------------------------------------------------------------------------
  // FSM: next state (clr > stop > start)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (!stop && start && w_len_ok) w_state_nxt = c_st_run;
        c_st_run:  if (stop)                       w_state_nxt = c_st_hold;
        c_st_hold: if (!stop && start)             w_state_nxt = c_st_run;
        default:                                   w_state_nxt = c_st_idle;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy  = (r_state == c_st_run);
    wrap  = r_wrap;
    char0 = r_char[0];
    char1 = r_char[1];
    char2 = r_char[2];
    char3 = r_char[3];
    char4 = r_char[4];
    char5 = r_char[5];
    char6 = r_char[6];
    char7 = r_char[7];
  end

  // --------------------------------------------------------------------------
  // Scroll timing and offset
  // --------------------------------------------------------------------------
  assign w_load  = !clr && !stop && start && w_len_ok && (r_state == c_st_idle);
  assign w_tick  = !clr && !stop && (r_state == c_st_run);
  assign w_shift = w_tick && (r_div == c_div_last);
  assign w_last  = 4'(r_len - 5'd1);

  always_comb begin
    if (dir) begin
      w_wraps   = (r_ofs == 4'd0);
      w_ofs_nxt = w_wraps ? w_last : (r_ofs - 4'd1);
    end else begin
      w_wraps   = (r_ofs == w_last);
      w_ofs_nxt = w_wraps ? 4'd0 : (r_ofs + 4'd1);
    end
  end

  // div is left untouched outside RUN, so HOLD resumes mid-period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= 5'd1;
      r_ofs  <= 4'd0;
      r_div  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_shift && w_wraps;
      if (clr || w_load) begin
        r_ofs <= 4'd0;
        r_div <= '0;
      end else if (w_tick) begin
        if (w_shift) begin
          r_div <= '0;
          r_ofs <= w_ofs_nxt;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
      if (w_load) begin
        r_len <= msg_len;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Message buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= c_blank;
      end
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Window indices: ofs is always below len, so a wrapping increment chain
  // gives (ofs + k) mod len without a divider.
  // --------------------------------------------------------------------------
  always_comb begin
    w_idx[0] = r_ofs;
    for (int k = 1; k < 8; k++) begin
      w_idx[k] = (w_idx[k-1] == w_last) ? 4'd0 : (w_idx[k-1] + 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        r_char[k] <= c_blank;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        r_char[7-k] <= (r_state == c_st_idle) ? c_blank : r_buf[w_idx[k]];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scroll_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_scroll_controller
// Function : Directed self-checking bench for scroll_controller (SHIFT_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scroll_controller;

  localparam logic [39:0] c_blank_fr = {8{5'd16}};
  localparam logic [39:0] c_eight_fr = {8{5'd8}};
  localparam logic [39:0] c_f0 = {5'd10, 5'd11, 5'd13, 5'd13, 5'd0,  5'd10, 5'd11, 5'd13};
  localparam logic [39:0] c_f1 = {5'd11, 5'd13, 5'd13, 5'd0,  5'd10, 5'd11, 5'd13, 5'd13};
  localparam logic [39:0] c_f4 = {5'd0,  5'd10, 5'd11, 5'd13, 5'd13, 5'd0,  5'd10, 5'd11};
  localparam logic [39:0] c_f3 = {5'd13, 5'd0,  5'd10, 5'd11, 5'd13, 5'd13, 5'd0,  5'd10};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [4:0] wr_data = 5'd0;
  logic [4:0] msg_len = 5'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clr = 1'b0;
  logic       dir = 1'b0;
  logic [4:0] char0, char1, char2, char3, char4, char5, char6, char7;
  logic       busy;
  logic       wrap;
  logic [39:0] w_frame;

  int n_checks = 0;
  int n_pass   = 0;

  scroll_controller #(.SHIFT_DIV(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .msg_len (msg_len),
    .start   (start),
    .stop    (stop),
    .clr     (clr),
    .dir     (dir),
    .char0   (char0),
    .char1   (char1),
    .char2   (char2),
    .char3   (char3),
    .char4   (char4),
    .char5   (char5),
    .char6   (char6),
    .char7   (char7),
    .busy    (busy),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  assign w_frame = {char7, char6, char5, char4, char3, char2, char1, char0};

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // advance n clock edges, ending 1 time unit after the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] len);
    msg_len = len; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    int nw;
    int at;
    int bad;
    logic [11:0] mask;

    // reset state
    step(2);
    rst = 1'b0;
    step(1);
    check("reset_frame", w_frame, c_blank_fr);
    check("reset_busy", 40'(busy), 40'(0));
    check("reset_wrap", 40'(wrap), 40'(0));

    // load HELLO while idle: display stays blank
    wr(4'd0, 5'd10); wr(4'd1, 5'd11); wr(4'd2, 5'd13); wr(4'd3, 5'd13); wr(4'd4, 5'd0);
    step(1);
    check("idle_after_write", w_frame, c_blank_fr);

    // dir=0 run
    dir = 1'b0;
    pulse_start(5'd5);                       // after edge N
    check("run_busy", 40'(busy), 40'(1));
    step(1);                                 // N+1
    check("hello_ofs0", w_frame, c_f0);
    step(3);                                 // N+4: ofs updated, chars not yet
    check("ofs1_not_yet", w_frame, c_f0);
    check("no_wrap_n4", 40'(wrap), 40'(0));
    step(1);                                 // N+5
    check("hello_ofs1", w_frame, c_f1);
    nw = 0; at = -1;
    for (int i = 6; i <= 24; i++) begin
      step(1);
      if (wrap) begin
        nw++;
        at = i;
      end
    end
    check("wrap_count_left", 40'(nw), 40'(1));
    check("wrap_edge_left", 40'(at), 40'(20));
    pulse_clr();
    check("clr_busy", 40'(busy), 40'(0));
    step(1);
    check("clr_frame", w_frame, c_blank_fr);

    // dir=1 run; also shows the buffer survived clr
    dir = 1'b1;
    pulse_start(5'd5);
    step(1);                                 // N+1
    check("buf_kept_after_clr", w_frame, c_f0);
    step(3);                                 // N+4
    check("wrap_right_n4", 40'(wrap), 40'(1));
    step(1);                                 // N+5
    check("right_ofs4", w_frame, c_f4);
    check("wrap_right_n5", 40'(wrap), 40'(0));

    // stop two cycles after the shift: div frozen at 1
    stop = 1'b1;
    step(1);                                 // N+6
    stop = 1'b0;
    check("hold_busy", 40'(busy), 40'(0));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (busy !== 1'b0 || w_frame !== c_f4) bad++;
    end
    check("hold_frozen", 40'(bad), 40'(0));
    start = 1'b1;
    step(1);                                 // P
    start = 1'b0;
    check("resume_busy", 40'(busy), 40'(1));
    step(3);                                 // P+3: shift edge
    check("resume_pre_shift", w_frame, c_f4);
    step(1);                                 // P+4
    check("resume_shifted", w_frame, c_f3);

    // start+stop together in RUN -> HOLD, then in HOLD -> no change
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_run", 40'(busy), 40'(0));
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_hold", 40'(busy), 40'(0));
    check("startstop_frame", w_frame, c_f3);
    pulse_clr();

    // illegal lengths are ignored
    pulse_start(5'd0);
    check("len0_busy", 40'(busy), 40'(0));
    step(1);
    check("len0_frame", w_frame, c_blank_fr);
    pulse_start(5'd17);
    check("len17_busy", 40'(busy), 40'(0));
    step(1);
    check("len17_frame", w_frame, c_blank_fr);

    // single-character message
    wr(4'd0, 5'd8);
    dir = 1'b0;
    pulse_start(5'd1);                       // N
    step(1);                                 // N+1
    check("len1_frame", w_frame, c_eight_fr);
    mask = 12'd0;
    mask[0] = wrap;
    for (int i = 1; i < 12; i++) begin
      step(1);
      mask[i] = wrap;
    end
    check("len1_wrap_mask", 40'(mask), 40'(12'h888));

    // asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 40'(busy), 40'(0));
    check("arst_frame", w_frame, c_blank_fr);
    check("arst_wrap", 40'(wrap), 40'(0));
    #1 rst = 1'b0;
    step(1);

    // after reset every buffer entry must read blank
    pulse_start(5'd16);
    check("len16_busy", 40'(busy), 40'(1));
    step(1);
    check("buf_lo_blank", w_frame, c_blank_fr);
    step(32);
    check("buf_hi_blank", w_frame, c_blank_fr);

    // clr during RUN
    pulse_clr();
    check("clr_run_busy", 40'(busy), 40'(0));
    step(1);
    check("clr_run_frame", w_frame, c_blank_fr);
    check("clr_run_wrap", 40'(wrap), 40'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
